s3_cse: RTL
===========

S3_CSE -- requirements
Module: s3_cse

Interface
REQ-001 SHALL have parameter GF_POLY, default 9'h11D, GF(2^8) primitive polynomial; alpha = 8'h02.
REQ-002 SHALL have parameter N, default 255, codeword length; this block supports only 255.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port kes_done  input  1  one-cycle start pulse; lambda/omega valid in the same cycle.
REQ-006 SHALL have ports rs_lambda0, rs_lambda1, rs_lambda2  input  8 each  locator coefficients of x^0, x^1, x^2.
REQ-007 SHALL have ports rs_omega0, rs_omega1  input  8 each  evaluator coefficients of x^0, x^1.
REQ-008 SHALL have port cse_vld  output  1  one error value per symbol position.
REQ-009 SHALL have port cse_pos  output  8  symbol position; 254 down to 0 (254 = first received byte).
REQ-010 SHALL have port cse_err  output  8  error value to XOR into the symbol; 0 = no error.
REQ-011 SHALL have port cse_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port cse_err_cnt  output  2  number of roots found; valid with cse_done and held afterwards.
REQ-013 SHALL have port cse_fail  output  1  uncorrectable flag; valid with cse_done and held afterwards.

Function
REQ-014 SHALL implement FSM IDLE -> INV -> SRCH -> DONE -> IDLE, one-hot encoded.
REQ-015 IDLE: on a clk edge with kes_done=1, SHALL capture all five coefficients and enter INV; kes_done outside IDLE SHALL be ignored.
REQ-016 INV SHALL last exactly 7 cycles and compute inv = lambda1^254 by square-and-multiply: acc=1, sq=lambda1^2; each cycle acc=acc*sq, sq=sq^2.
REQ-017 On INV entry SHALL load Chien registers L1=lambda1*alpha, L2=lambda2*alpha^2, O1=omega1*alpha, and X=alpha^254 (8'h8E).
REQ-018 SRCH SHALL last exactly 255 cycles with step k=0..254 and position p=254-k.
REQ-019 Each SRCH step SHALL evaluate s=lambda0^L1^L2; root=(s==0); e=X*(omega0^O1)*inv.
REQ-020 Each SRCH step SHALL then update L1*=alpha, L2*=alpha^2, O1*=alpha, X*=alpha^-1 (8'h8E).
REQ-021 Step k SHALL be registered onto the outputs at the following edge: cse_vld=1, cse_pos=p, cse_err=(root ? e : 0).
REQ-022 Outside SRCH outputs SHALL be cse_vld=0, cse_pos=0, cse_err=0.
REQ-023 A root counter SHALL saturate at 3 and be cleared on leaving IDLE.
REQ-024 Expected degree deg SHALL be 2 if lambda2!=0, else 1 if lambda1!=0, else 0.
REQ-025 DONE SHALL last 1 cycle, with cse_done=1 registered, cse_err_cnt=min(count,3), and cse_fail as defined in REQ-026 and REQ-027.
REQ-026 cse_fail SHALL be 1 if count!=deg.
REQ-027 cse_fail SHALL be 1 if lambda1==0 and lambda2!=0 (repeated root); in that case every cse_err SHALL be forced to 0.
REQ-028 lambda1=lambda2=0 SHALL give deg=0, all cse_err=0, cnt=0 and fail=0 (error-free word).
REQ-029 Latency: with kes_done sampled at edge T0, cse_vld SHALL be high for edges T0+8..T0+262 and cse_done SHALL pulse at edge T0+263.
REQ-030 Throughput SHALL be one codeword per 264 cycles; the block SHALL be ready for a new kes_done at edge T0+264.
REQ-031 The result SHALL be invariant to a common nonzero scale of lambda and omega.
REQ-032 All GF multiplies SHALL use the existing gf2m8_multi cell; constant multiplies may be hardwired XOR networks.

Reset
REQ-033 rstn=0 SHALL asynchronously force IDLE and clear all coefficient, Chien and INV registers.
REQ-034 rstn=0 SHALL force cse_vld, cse_pos, cse_err, cse_done, cse_err_cnt and cse_fail to 0.
REQ-035 Reset asserted mid-INV or mid-SRCH SHALL abort with no further cse_vld or cse_done until a new kes_done.

Verification
REQ-036 lambda=(01,01,00), omega=(5A,00) -> 255 vld cycles; only pos 0 has err=5A; cnt=1, fail=0.
REQ-037 lambda=(02,02,00), omega=(B4,00) -> identical output to REQ-036 (scale invariance).
REQ-038 lambda=(01,8E,00), omega=(33,00) -> only pos 254 (first vld cycle) has err=33; cnt=1, fail=0.
REQ-039 lambda=(00,00,00), omega=(00,00) -> all err=0; cnt=0, fail=0; cse_done at T0+263.
REQ-040 lambda=(01,00,01) -> all err=0; fail=1; second kes_done pulse during SRCH ignored, timing unchanged.
REQ-041 rstn pulse at T0+100 -> cse_vld drops immediately, no cse_done; new kes_done restarts with full latency.

Source files
------------

// File: rtl/s3_cse.sv
// Chien search / Forney error evaluator for a t=2 RS(255) decoder over GF(2^8).
// Takes lambda/omega from the key-equation solver and emits one error value per symbol.

module gf2m8_multi #(
  parameter logic [8:0] GF_POLY = 9'h11D
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
    end
    p = acc;
  end
endmodule

module s3_cse #(
  parameter logic [8:0] GF_POLY = 9'h11D,
  parameter int         N       = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       kes_done,
  input  logic [7:0] rs_lambda0,
  input  logic [7:0] rs_lambda1,
  input  logic [7:0] rs_lambda2,
  input  logic [7:0] rs_omega0,
  input  logic [7:0] rs_omega1,
  output logic       cse_vld,
  output logic [7:0] cse_pos,
  output logic [7:0] cse_err,
  output logic       cse_done,
  output logic [1:0] cse_err_cnt,
  output logic       cse_fail,
  output logic [3:0] dbg_state
);

  // Handshake: kes_done is a fire-and-forget start pulse with its coefficients valid in
  // the same cycle; there is no ready, pulses arriving outside IDLE are dropped.
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_INV  = 4'b0010;
  localparam logic [3:0] S_SRCH = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;

  function automatic logic [7:0] mul_a(input logic [7:0] v);
    return v[7] ? ({v[6:0], 1'b0} ^ GF_POLY[7:0]) : {v[6:0], 1'b0};
  endfunction

  // Multiply by alpha^-1: shift right, folding the polynomial back in when bit 0 is set.
  function automatic logic [7:0] div_a(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ GF_POLY[8:1]) : (v >> 1);
  endfunction

  localparam logic [7:0] LAST_STEP = 8'(N - 1);
  localparam logic [7:0] INV_LAST  = 8'd6;
  localparam logic [7:0] X_INIT    = div_a(8'h01);

  logic [3:0] state_q, state_d;
  logic [7:0] step_q, step_d;
  logic [7:0] lam0_q, lam0_d, lam1_q, lam1_d, lam2_q, lam2_d, om0_q, om0_d;
  logic [7:0] l1_q, l1_d, l2_q, l2_d, o1_q, o1_d, x_q, x_d;
  logic [7:0] acc_q, acc_d, sq_q, sq_d;
  logic [1:0] root_cnt_q, root_cnt_d;
  logic       vld_q, vld_d, done_q, done_d, fail_q, fail_d;
  logic [7:0] pos_q, pos_d, err_q, err_d;
  logic [1:0] err_cnt_q, err_cnt_d;

  logic [7:0] sq_in, sq_sq, acc_sq, e_pre, e_val, s_val;
  logic       no_loc, rep_root, root;
  logic [1:0] deg;

  assign sq_in    = (state_q == S_IDLE) ? rs_lambda1 : sq_q;
  assign s_val    = lam0_q ^ l1_q ^ l2_q;
  assign no_loc   = (lam1_q == 8'h00) && (lam2_q == 8'h00);
  assign rep_root = (lam1_q == 8'h00) && (lam2_q != 8'h00);
  assign root     = (s_val == 8'h00) && !no_loc;
  assign deg      = (lam2_q != 8'h00) ? 2'd2 : ((lam1_q != 8'h00) ? 2'd1 : 2'd0);

  gf2m8_multi #(.GF_POLY(GF_POLY)) u_sq  (.a(sq_in), .b(sq_in), .p(sq_sq));
  gf2m8_multi #(.GF_POLY(GF_POLY)) u_acc (.a(acc_q), .b(sq_q),  .p(acc_sq));
  gf2m8_multi #(.GF_POLY(GF_POLY)) u_e1  (.a(x_q),   .b(om0_q ^ o1_q), .p(e_pre));
  gf2m8_multi #(.GF_POLY(GF_POLY)) u_e2  (.a(e_pre), .b(acc_q), .p(e_val));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    lam0_d     = lam0_q;
    lam1_d     = lam1_q;
    lam2_d     = lam2_q;
    om0_d      = om0_q;
    l1_d       = l1_q;
    l2_d       = l2_q;
    o1_d       = o1_q;
    x_d        = x_q;
    acc_d      = acc_q;
    sq_d       = sq_q;
    root_cnt_d = root_cnt_q;
    vld_d      = 1'b0;
    pos_d      = 8'h00;
    err_d      = 8'h00;
    done_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    fail_d     = fail_q;
    case (state_q)
      S_IDLE: begin
        if (kes_done) begin
          lam0_d     = rs_lambda0;
          lam1_d     = rs_lambda1;
          lam2_d     = rs_lambda2;
          om0_d      = rs_omega0;
          l1_d       = mul_a(rs_lambda1);
          l2_d       = mul_a(mul_a(rs_lambda2));
          o1_d       = mul_a(rs_omega1);
          x_d        = X_INIT;
          acc_d      = 8'h01;
          sq_d       = sq_sq;
          step_d     = 8'h00;
          root_cnt_d = 2'd0;
          state_d    = S_INV;
        end
      end
      S_INV: begin
        // Seven square-and-multiply rounds leave acc = lambda1^(2+4+..+128) = lambda1^-1.
        acc_d = acc_sq;
        sq_d  = sq_sq;
        if (step_q == INV_LAST) begin
          step_d  = 8'h00;
          state_d = S_SRCH;
        end else begin
          step_d = step_q + 8'h01;
        end
      end
      S_SRCH: begin
        vld_d = 1'b1;
        pos_d = LAST_STEP - step_q;
        err_d = (root && !rep_root) ? e_val : 8'h00;
        if (root && (root_cnt_q != 2'd3)) root_cnt_d = root_cnt_q + 2'd1;
        l1_d = mul_a(l1_q);
        l2_d = mul_a(mul_a(l2_q));
        o1_d = mul_a(o1_q);
        x_d  = div_a(x_q);
        if (step_q == LAST_STEP) begin
          step_d  = 8'h00;
          state_d = S_DONE;
        end else begin
          step_d = step_q + 8'h01;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        err_cnt_d = root_cnt_q;
        fail_d    = (root_cnt_q != deg) || rep_root;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      lam0_q     <= '0;
      lam1_q     <= '0;
      lam2_q     <= '0;
      om0_q      <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      o1_q       <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      sq_q       <= '0;
      root_cnt_q <= '0;
      vld_q      <= 1'b0;
      pos_q      <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      lam0_q     <= lam0_d;
      lam1_q     <= lam1_d;
      lam2_q     <= lam2_d;
      om0_q      <= om0_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      o1_q       <= o1_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      sq_q       <= sq_d;
      root_cnt_q <= root_cnt_d;
      vld_q      <= vld_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      fail_q     <= fail_d;
    end
  end

  assign cse_vld     = vld_q;
  assign cse_pos     = pos_q;
  assign cse_err     = err_q;
  assign cse_done    = done_q;
  assign cse_err_cnt = err_cnt_q;
  assign cse_fail    = fail_q;
  assign dbg_state   = state_q;

endmodule
